// File: rtl/adc_scheduler.sv
// Round-robin ADC channel sequencer: steps through the channels enabled in a
// 16-bit mask, requests each one from the AVR interface, and waits for the
// matching sample or a timeout. Keeps the latest result per channel in a
// register file with a registered read port.
module adc_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic [15:0] i_en_mask,
    output logic [3:0]  o_channel,
    input  logic        i_new_sample,
    input  logic [9:0]  i_sample,
    input  logic [3:0]  i_sample_channel,
    output logic        o_result_valid,
    output logic [9:0]  o_result_data,
    output logic [3:0]  o_result_ch,
    output logic        o_timeout_err,
    output logic        o_sweep_done,
    output logic        o_busy,
    input  logic [3:0]  i_rd_ch,
    output logic [9:0]  o_rd_data,
    output logic        o_rd_valid
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSelect, StWait} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [3:0]          r_ch;
    logic [3:0]          r_channel;
    logic [15:0]         r_mask;
    logic [TimerW-1:0]   r_timer;
    logic                r_result_valid;
    logic [9:0]          r_result_data;
    logic [3:0]          r_result_ch;
    logic                r_timeout_err;
    logic                r_sweep_done;
    logic [9:0]          r_regfile [16];
    logic [15:0]         r_written;
    logic [9:0]          r_rd_data;
    logic                r_rd_valid;

    logic                w_in_wait;
    logic                w_match;
    logic                w_timeout;
    logic                w_exit;
    logic                w_last;
    logic [3:0]          w_next_ch;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_run && (i_en_mask != 16'd0)) w_state_next = StSelect;
            StSelect: w_state_next = (i_en_mask == 16'd0) ? StIdle : StWait;
            StWait:   if (w_exit) w_state_next = i_run ? StSelect : StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Output decode: match has priority over timeout in the same cycle.
    always_comb begin
        w_in_wait = (r_state == StWait);
        w_match   = w_in_wait && i_new_sample && (i_sample_channel == r_ch);
        w_timeout = w_in_wait && !w_match && (r_timer == TimerLast);
        w_exit    = w_match || w_timeout;
        o_busy    = (r_state != StIdle);
    end

    // First enabled channel searching upward from r_ch+1, wrapping; r_ch itself is tried last.
    always_comb begin
        logic [3:0] idx;
        logic       found;
        w_next_ch = r_ch;
        found     = 1'b0;
        idx       = r_ch;
        for (int i = 1; i <= 16; i++) begin
            idx = r_ch + 4'(i);
            if (!found && i_en_mask[idx]) begin
                w_next_ch = idx;
                found     = 1'b1;
            end
        end
    end

    // Current channel is the last of the pass when no latched mask bit lies above it.
    always_comb begin
        w_last = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ((i > int'(r_ch)) && r_mask[i]) w_last = 1'b0;
        end
    end

    // Channel pointer, timer and registered result/status pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ch           <= 4'd15;
            r_channel      <= 4'd0;
            r_mask         <= 16'd0;
            r_timer        <= '0;
            r_result_valid <= 1'b0;
            r_result_data  <= 10'd0;
            r_result_ch    <= 4'd0;
            r_timeout_err  <= 1'b0;
            r_sweep_done   <= 1'b0;
        end else begin
            r_result_valid <= w_match;
            r_timeout_err  <= w_timeout;
            r_sweep_done   <= w_exit && w_last;
            if (w_match) begin
                r_result_data <= i_sample;
                r_result_ch   <= r_ch;
            end
            if ((r_state == StSelect) && (i_en_mask != 16'd0)) begin
                r_ch      <= w_next_ch;
                r_channel <= w_next_ch;
                r_mask    <= i_en_mask;
                r_timer   <= '0;
            end else if (w_in_wait) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Register file and written flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) r_regfile[i] <= 10'd0;
            r_written <= 16'd0;
        end else if (w_match) begin
            r_regfile[r_ch] <= i_sample;
            r_written[r_ch] <= 1'b1;
        end
    end

    // Registered read port; a same-edge write shows up one cycle later.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data  <= 10'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= r_regfile[i_rd_ch];
            r_rd_valid <= r_written[i_rd_ch];
        end
    end

    assign o_channel      = r_channel;
    assign o_result_valid = r_result_valid;
    assign o_result_data  = r_result_data;
    assign o_result_ch    = r_result_ch;
    assign o_timeout_err  = r_timeout_err;
    assign o_sweep_done   = r_sweep_done;
    assign o_rd_data      = r_rd_data;
    assign o_rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_adc_scheduler.sv
// Scoreboard bench for adc_scheduler: a driver plays the AVR side and pushes
// expected result/timeout events; a monitor pops them when pulses appear.
module tb_adc_scheduler;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] en_mask;
    logic [3:0]  channel;
    logic        new_sample;
    logic [9:0]  sample;
    logic [3:0]  sample_channel;
    logic        result_valid;
    logic [9:0]  result_data;
    logic [3:0]  result_ch;
    logic        timeout_err;
    logic        sweep_done;
    logic        busy;
    logic [3:0]  rd_ch;
    logic [9:0]  rd_data;
    logic        rd_valid;

    adc_scheduler #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_en_mask(en_mask),
        .o_channel(channel), .i_new_sample(new_sample), .i_sample(sample),
        .i_sample_channel(sample_channel), .o_result_valid(result_valid),
        .o_result_data(result_data), .o_result_ch(result_ch),
        .o_timeout_err(timeout_err), .o_sweep_done(sweep_done), .o_busy(busy),
        .i_rd_ch(rd_ch), .o_rd_data(rd_data), .o_rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_to;
        logic [3:0] ch;
        logic [9:0] data;
        bit         sweep;
        int         due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [9:0]  m_reg [16];
    bit   [15:0] m_wr;
    logic [3:0]  m_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Next enabled channel after prev, wrapping around 16 channels.
    function automatic logic [3:0] next_en(input logic [3:0] prev, input logic [15:0] m);
        int c;
        for (int k = 1; k <= 16; k++) begin
            c = (int'(prev) + k) % 16;
            if (m[c]) return 4'(c);
        end
        return prev;
    endfunction

    // Monitor: every pulse must match the head of the queue on its due cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            mon_e = q.pop_front();
            if (mon_e.is_to) begin
                chk("timeout_err", timeout_err, 1);
                chk("no result_valid on timeout", result_valid, 0);
                chk("channel at timeout", channel, mon_e.ch);
            end else begin
                chk("result_valid", result_valid, 1);
                chk("no timeout_err on result", timeout_err, 0);
                chk("result_data", result_data, mon_e.data);
                chk("result_ch", result_ch, mon_e.ch);
            end
            chk("sweep_done", sweep_done, mon_e.sweep);
        end else if (result_valid === 1'b1 || timeout_err === 1'b1 || sweep_done === 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected pulse: rv=%b to=%b sd=%b, want none (cycle %0d)",
                     result_valid, timeout_err, sweep_done, cyc);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        new_sample = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset channel", channel, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset result_data", result_data, 0);
        chk("reset result_ch", result_ch, 0);
        chk("reset timeout_err", timeout_err, 0);
        chk("reset sweep_done", sweep_done, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_valid", rd_valid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_reg[i] = 10'd0;
        m_wr = 16'd0;
        m_prev = 4'd15;
    endtask

    // Called at an IDLE negedge; returns at the negedge of the first WAIT cycle.
    task automatic start_run(input logic [15:0] m);
        en_mask = m;
        run = 1'b1;
        @(negedge clk);
        chk("busy in select", busy, 1);
        @(negedge clk);
    endtask

    // One channel service, entered at the negedge of WAIT cycle 0.
    // d < 0: silent (timeout). val < 0: answer 10*ch+1. junk: 0 none, 1 random, 2 every cycle.
    task automatic service(input int d, input int junk, input int val, input bit stop,
                           input logic [15:0] nmask);
        logic [15:0] sm;
        logic [3:0]  c;
        logic [9:0]  v;
        bit          last;
        bit          done;
        exp_t        e;
        sm = en_mask;
        c = next_en(m_prev, sm);
        m_prev = c;
        last = ((int'(sm) >> (int'(c) + 1)) == 0);
        v = (val < 0) ? 10'(10 * int'(c) + 1) : 10'(val);
        chk("channel", channel, c);
        chk("busy in wait", busy, 1);
        rd_ch = c;
        en_mask = nmask;
        if (stop) run = 1'b0;
        done = 1'b0;
        for (int j = 0; j < int'(T) && !done; j++) begin
            if (j > 0) @(negedge clk);
            new_sample = 1'b0;
            sample = 10'($urandom);
            if (j == d) begin
                new_sample = 1'b1;
                sample_channel = c;
                sample = v;
                e.is_to = 1'b0;
                done = 1'b1;
            end else begin
                if (junk == 2 || (junk == 1 && $urandom_range(0, 1) == 1)) begin
                    new_sample = 1'b1;
                    sample_channel = (junk == 2) ? c + 4'd1 : c ^ 4'($urandom_range(1, 15));
                end
                if (j == int'(T) - 1) begin
                    e.is_to = 1'b1;
                    done = 1'b1;
                end
            end
            if (done) begin
                e.ch = c;
                e.data = v;
                e.sweep = last;
                e.due = cyc + 1;
                q.push_back(e);
            end
        end
        @(negedge clk);
        new_sample = 1'b0;
        chk("rd_data before write", rd_data, m_reg[c]);
        chk("rd_valid before write", rd_valid, m_wr[c]);
        if (!e.is_to) begin
            m_reg[c] = v;
            m_wr[c] = 1'b1;
        end
        if (stop) chk("busy after stop", busy, 0);
        @(negedge clk);
        chk("rd_data after write", rd_data, m_reg[c]);
        chk("rd_valid after write", rd_valid, m_wr[c]);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            rd_ch = 4'(i);
            @(negedge clk);
            chk("read rd_data", rd_data, m_reg[i]);
            chk("read rd_valid", rd_valid, m_wr[i]);
        end
    endtask

    function automatic logic [15:0] rand_mask();
        logic [15:0] m;
        m = 16'($urandom) & 16'($urandom);
        if (m == 16'd0) m = 16'd1 << $urandom_range(0, 15);
        return m;
    endfunction

    initial begin
        logic [15:0] nm;
        int          d;
        int          r;
        bit          stop;
        rst_n = 1'b0;
        run = 1'b0;
        en_mask = 16'd0;
        new_sample = 1'b0;
        sample = 10'd0;
        sample_channel = 4'd0;
        rd_ch = 4'd0;
        repeat (2) @(negedge clk);
        do_reset();

        // Two-channel scan, answers 3 cycles into each WAIT.
        start_run(16'h0005);
        service(3, 0, -1, 0, 16'h0005);
        service(3, 0, -1, 0, 16'h0005);
        service(3, 0, -1, 0, 16'h0005);
        service(3, 0, -1, 1, 16'h0005);
        read_all();

        // Wrap 15 -> 0.
        start_run(16'h8001);
        service(1, 0, -1, 0, 16'h8001);
        service(2, 0, -1, 0, 16'h8001);
        service(0, 0, -1, 1, 16'h8001);

        // Silent channel 3 times out, then channel 4 is serviced.
        do_reset();
        start_run(16'h0018);
        service(-1, 1, 0, 0, 16'h0018);
        service(2, 0, -1, 1, 16'h0018);
        read_all();

        // Foreign strobes ignored on channel 1.
        start_run(16'h0002);
        service(4, 2, 10'h3FF, 1, 16'h0002);

        // Reset in the middle of a WAIT.
        start_run(16'h00F0);
        repeat (2) @(negedge clk);
        do_reset();
        read_all();

        // Single channel, match on the exact timeout cycle.
        start_run(16'h0010);
        service(int'(T) - 1, 1, 10'h155, 0, 16'h0010);
        service(int'(T) - 1, 0, 10'h2AA, 0, 16'h0010);
        service(1, 0, -1, 1, 16'h0010);

        // Randomized traffic.
        start_run(rand_mask());
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 19);
            if (r < 3) d = -1;
            else if (r < 5) d = int'(T) - 1;
            else if (r < 7) d = 0;
            else d = $urandom_range(0, T - 1);
            nm = ($urandom_range(0, 3) == 0) ? rand_mask() : en_mask;
            stop = ($urandom_range(0, 9) == 0) || (n == 79);
            service(d, $urandom_range(0, 1), int'($urandom_range(0, 1023)), stop, nm);
            if (stop) begin
                if ($urandom_range(0, 2) == 0) read_all();
                if (n != 79) start_run(en_mask);
            end
        end
        read_all();
        repeat (3) @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_scheduler.md
# adc_scheduler

Round-robin sequencer for the AVR ADC path. Drives the 4-bit channel select into the AVR interface block and waits for the matching sample, with a timeout. Stores the latest 10-bit result per channel in a register file and steps through the channels enabled by a 16-bit mask. Sits between the AVR interface and the application logic that consumes sensor readings.

## Interface
- `TIMEOUT_CYCLES`, 50000: max cycles to wait for a matching sample before giving up on a channel (≥2).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `run`  in  1  level; scan while high.
- `en_mask`  in  16  bit i enables channel i; sampled only in SELECT.
- `channel`  out  4  channel request to AVR interface.
- `new_sample`  in  1  one-cycle strobe from AVR interface.
- `sample`  in  10  ADC value, valid with `new_sample`.
- `sample_channel`  in  4  channel the sample belongs to, valid with `new_sample`.
- `result_valid`  out  1  one-cycle pulse: a result was stored.
- `result_data`  out  10  stored value, valid with `result_valid`.
- `result_ch`  out  4  channel of stored value, valid with `result_valid`.
- `timeout_err`  out  1  one-cycle pulse: current channel timed out.
- `sweep_done`  out  1  one-cycle pulse: last enabled channel of a pass completed (result or timeout).
- `busy`  out  1  high in SELECT/WAIT.
- `rd_ch`  in  4  register-file read address.
- `rd_data`  out  10  value for `rd_ch`, registered.
- `rd_valid`  out  1  channel `rd_ch` written at least once since reset, registered.

## Operation
- States: IDLE, SELECT, WAIT.
- IDLE → SELECT when `run`=1 and `en_mask`≠0; otherwise stay.
- SELECT: if `en_mask`=0, go to IDLE. Otherwise load `ch_q` with the first set bit of `en_mask` searching upward from `ch_q`+1 mod 16 (wraps 15→0; may reselect `ch_q` itself if it is the only enabled channel). Latch `en_mask` into `mask_q`, clear timer, → WAIT.
- WAIT: timer increments each cycle.
  - Match (`new_sample`=1 and `sample_channel`=`ch_q`): write `sample` into `regfile[ch_q]`, set `written[ch_q]`, pulse `result_valid`.
  - Non-matching strobes are discarded and do not reset the timer.
  - No match and timer = `TIMEOUT_CYCLES`-1: pulse `timeout_err`; regfile unchanged.
  - On either exit: → SELECT if `run`=1, else IDLE. `sweep_done` pulses with the exit if `mask_q` has no set bit above `ch_q`.
- Match and timeout in the same cycle: the match wins; no `timeout_err`.
- `run` deasserted or `en_mask` changed during WAIT: the current channel completes normally (match or timeout) before the change takes effect.
- `channel` = `ch_q` at all times. It holds its value in IDLE.
- Reset (any state, mid-WAIT included): state IDLE, `ch_q`=15 (first pass starts at the lowest enabled channel), timer 0, `channel`=0, all pulses 0, `busy`=0, regfile and `written` cleared, `rd_data`=0, `rd_valid`=0.

## Timing
- `channel` changes on the clock edge that enters WAIT, so it is registered.
- Matching `new_sample` seen at edge N: `result_valid`/`result_data`/`result_ch` are high for exactly cycle N+1, and the state is SELECT at N+1.
- A match can be accepted on the first WAIT cycle.
- Minimum per-channel period: 2 cycles (SELECT + WAIT).
- Timeout: `timeout_err` is asserted `TIMEOUT_CYCLES`+1 cycles after SELECT (TIMEOUT_CYCLES WAIT cycles + registered pulse).
- Read port: `rd_data`/`rd_valid` reflect `rd_ch` sampled at the previous edge.
- Read of a channel being written on the same edge returns the old value; the new value appears one cycle later.
- `sweep_done` is coincident with the `result_valid` or `timeout_err` of the last enabled channel.

## Test plan
- Reset, `en_mask`=16'h0005, `run`=1, AVR model answers 3 cycles after each channel change with value 10×ch+1. Required: `channel` sequence 0,2,0,2…; results (0,1),(2,21); `sweep_done` only with ch 2; `rd_ch`=2 → `rd_data`=21, `rd_valid`=1.
- `en_mask`=16'h8001 with `ch_q` at 15. Required: next channel is 0 (wrap); `sweep_done` with ch 15.
- `TIMEOUT_CYCLES`=8, model silent on ch 3 (`en_mask`=16'h0018). Required: `timeout_err` 9 cycles after SELECT, regfile[3] unchanged, `rd_valid`(3)=0, then ch 4 is serviced.
- In WAIT on ch 1, strobe with `sample_channel`=2, then ch 1 value 10'h3FF. Required: the first strobe is ignored; `result_data`=10'h3FF, `result_ch`=1.
- Drop `run` mid-WAIT. Required: current channel completes, then IDLE with `busy`=0. Assert `rst_n`=0 mid-WAIT on a second run. Required: all outputs 0 next cycle, `rd_valid`=0 for all channels.
- Single-channel mask 16'h0010 with the match arriving on the exact timeout cycle. Required: `result_valid`, no `timeout_err`, ch 4 reselected.
